// File: rtl/encoder_gen_pkg.sv
// encoder_gen_pkg: shared state encoding, phase constants, default widths and the
// quadrature A/B lookup used by the encoder emulator.
package encoder_gen_pkg;
  localparam int CNT_W_D = 24;
  localparam int PPR_W_D = 16;
  localparam int SYNC_W_D = 8;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
  // returns {A, B} for a quadrature phase
  function automatic logic [1:0] ab_of(input logic [1:0] q);
    return {(q == Q1) || (q == Q2), (q == Q2) || (q == Q3)};
  endfunction
endpackage

// File: rtl/enc_quarter_timer.sv
// enc_quarter_timer: loadable down-counter giving a one-clk step strobe every
// quarter clks; a quarter of 0 is taken as 1 and the period is latched on load.
module enc_quarter_timer
  import encoder_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_quarter,
  output logic             o_step
);
  logic [CNT_W-1:0] w_q;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  assign w_q = (i_quarter == '0) ? CNT_W'(1) : i_quarter;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_period <= CNT_W'(1);
      r_cnt <= '0;
    end else if (i_load) begin
      r_period <= w_q;
      r_cnt <= w_q - CNT_W'(1);
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? r_period - CNT_W'(1) : r_cnt - CNT_W'(1);
    end
  assign o_step = i_en & (r_cnt == '0);
endmodule

// File: rtl/encoder_gen.sv
// encoder_gen: quadrature A/B, index C and sync strobe emulator with shadowed config.
// Define ENC_BURST_EN to add cfg_burst/burst_done pulse-count limited runs.
module encoder_gen
  import encoder_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_D,
  parameter int PPR_W  = PPR_W_D,
  parameter int SYNC_W = SYNC_W_D
) (
  input  logic              clk,
  input  logic              mcu_n_rst,
  input  logic              gen_en,
  input  logic              cfg_load,
  input  logic [CNT_W-1:0]  cfg_quarter,
  input  logic [PPR_W-1:0]  cfg_ppr,
  input  logic [SYNC_W-1:0] cfg_sync_div,
  input  logic              cfg_dir,
`ifdef ENC_BURST_EN
  input  logic [31:0]       cfg_burst,
  output logic              burst_done,
`endif
  output logic              enc_a,
  output logic              enc_b,
  output logic              enc_c,
  output logic              enc_sync,
  output logic [PPR_W-1:0]  pulse_pos,
  output logic [15:0]       rev_cnt,
  output logic              busy
);
  state_t r_state, w_next;
  logic r_gen_d, r_sh_dir, r_dir, r_sync_pend;
  logic [CNT_W-1:0] r_sh_quarter;
  logic [PPR_W-1:0] r_sh_ppr, r_ppr, r_pos, w_ppr_m1;
  logic [SYNC_W-1:0] r_sh_div, r_div_cfg, r_div;
  logic [1:0] r_q, w_nq, w_ab;
  logic [15:0] r_rev;
  logic w_rise, w_start, w_step, w_land, w_wrap, w_sync, w_burst_hit, w_stop_req, w_busy, w_c;
  assign w_rise = gen_en & ~r_gen_d;
  assign w_start = (r_state == IDLE) & w_rise;
  assign w_nq = r_dir ? r_q - 2'd1 : r_q + 2'd1;
  assign w_land = w_step & (w_nq == Q0);
  assign w_ppr_m1 = r_ppr - PPR_W'(1);
  assign w_wrap = w_land & (r_dir ? (r_pos == '0) : (r_pos == w_ppr_m1));
  assign w_sync = w_wrap & (r_div_cfg != '0) & (r_div == r_div_cfg - SYNC_W'(1));
  assign w_stop_req = ~gen_en | w_burst_hit;
  assign pulse_pos = r_pos;
  assign rev_cnt = r_rev;
  enc_quarter_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst_n(mcu_n_rst), .i_load(w_start), .i_en(w_busy),
    .i_quarter(r_sh_quarter), .o_step(w_step)
  );
  always_ff @(posedge clk or negedge mcu_n_rst)
    if (!mcu_n_rst) r_state <= IDLE;
    else r_state <= w_next;
  // a stop request that coincides with a landing on Q0 skips STOP entirely
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_start ? RUN : IDLE;
    else if ((r_state == RUN && !w_stop_req) || (r_state == STOP && w_rise)) w_next = RUN;
    else w_next = w_land ? IDLE : STOP;
  end
  always_comb begin
    w_busy = r_state != IDLE;
    w_ab = ab_of(r_q);
    w_c = w_busy & (r_q == Q0) & (r_pos == '0);
  end
  always_ff @(posedge clk or negedge mcu_n_rst)
    if (!mcu_n_rst) begin
      r_gen_d <= 1'b0;
      r_sh_quarter <= CNT_W'(1);
      r_sh_ppr <= '0;
      r_sh_div <= '0;
      r_sh_dir <= 1'b0;
      r_ppr <= '0;
      r_div_cfg <= '0;
      r_dir <= 1'b0;
      r_q <= Q0;
      r_pos <= '0;
      r_div <= '0;
      r_rev <= '0;
      r_sync_pend <= 1'b0;
    end else begin
      r_gen_d <= gen_en;
      if (cfg_load) begin
        r_sh_quarter <= cfg_quarter;
        r_sh_ppr <= cfg_ppr;
        r_sh_div <= cfg_sync_div;
        r_sh_dir <= cfg_dir;
      end
      if (w_start) begin
        r_ppr <= r_sh_ppr;
        r_div_cfg <= r_sh_div;
        r_dir <= r_sh_dir;
        r_q <= Q0;
        r_pos <= '0;
        r_div <= '0;
      end else if (w_step) begin
        r_q <= w_nq;
        if (w_land) r_pos <= w_wrap ? (r_dir ? w_ppr_m1 : '0) : (r_dir ? r_pos - PPR_W'(1) : r_pos + PPR_W'(1));
        if (w_wrap) r_rev <= r_rev + 16'd1;
        if (w_wrap) r_div <= w_sync ? '0 : r_div + SYNC_W'(1);
      end
      r_sync_pend <= w_sync;
    end
  // sync is delayed one extra clk so it lines up with the registered enc_c rise
  always_ff @(posedge clk or negedge mcu_n_rst)
    if (!mcu_n_rst) {enc_a, enc_b, enc_c, enc_sync, busy} <= '0;
    else {enc_a, enc_b, enc_c, enc_sync, busy} <= {w_ab, w_c, r_sync_pend, w_busy};
`ifdef ENC_BURST_EN
  logic [31:0] r_sh_burst, r_burst, r_pcnt;
  assign w_burst_hit = w_land & (r_burst != '0) & (r_pcnt + 32'd1 == r_burst);
  always_ff @(posedge clk or negedge mcu_n_rst)
    if (!mcu_n_rst) begin
      r_sh_burst <= '0;
      r_burst <= '0;
      r_pcnt <= '0;
      burst_done <= 1'b0;
    end else begin
      if (cfg_load) r_sh_burst <= cfg_burst;
      if (w_start) begin
        r_burst <= r_sh_burst;
        r_pcnt <= '0;
      end else if (w_land) begin
        r_pcnt <= r_pcnt + 32'd1;
      end
      burst_done <= w_burst_hit & (r_state == RUN);
    end
`else
  assign w_burst_hit = 1'b0;
`endif
endmodule

// File: tb/tb_encoder_gen.sv
// tb_encoder_gen: scoreboard bench; expectations come from an analytic model of step
// times (start edge + k*quarter), queued when stimulus is driven and compared a clk later.
module tb_encoder_gen;
  localparam int BIG = 1 << 30;
  logic clk = 1'b0, mcu_n_rst = 1'b1, gen_en = 1'b0, cfg_load = 1'b0, cfg_dir = 1'b0;
  logic [23:0] cfg_quarter = '0;
  logic [15:0] cfg_ppr = '0;
  logic [7:0] cfg_sync_div = '0;
  logic enc_a, enc_b, enc_c, enc_sync, busy;
  logic [15:0] pulse_pos, rev_cnt;
`ifdef ENC_BURST_EN
  logic [31:0] cfg_burst = '0;
  logic burst_done;
`endif
  int cyc = 0, vectors = 0, errors = 0;
  int m_s = BIG, m_e = BIG, m_q = 1, m_ppr = 4, m_dir = 0, m_d = 0, m_rev0 = 0;
  int sh_q = 1, sh_ppr = 4, sh_d = 0, sh_dir = 0;
  logic [36:0] exp_q[$];

  encoder_gen dut (
    .clk(clk), .mcu_n_rst(mcu_n_rst), .gen_en(gen_en), .cfg_load(cfg_load),
    .cfg_quarter(cfg_quarter), .cfg_ppr(cfg_ppr), .cfg_sync_div(cfg_sync_div), .cfg_dir(cfg_dir),
`ifdef ENC_BURST_EN
    .cfg_burst(cfg_burst), .burst_done(burst_done),
`endif
    .enc_a(enc_a), .enc_b(enc_b), .enc_c(enc_c), .enc_sync(enc_sync),
    .pulse_pos(pulse_pos), .rev_cnt(rev_cnt), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int steps_at(input int n);
    int l;
    l = (n < m_e) ? n : m_e;
    return (l < m_s) ? 0 : (l - m_s) / m_q;
  endfunction
  function automatic int qv(input int k);
    return m_dir ? (4 - k % 4) % 4 : k % 4;
  endfunction
  function automatic int posv(input int p);
    return m_dir ? (m_ppr - p % m_ppr) % m_ppr : p % m_ppr;
  endfunction
  function automatic int wraps(input int p);
    return m_dir ? (p + m_ppr - 1) / m_ppr : p / m_ppr;
  endfunction
  function automatic int cur_rev();
    return m_rev0 + wraps(steps_at(cyc) / 4);
  endfunction
  function automatic int next_land(input int d);
    int k;
    k = (d - m_s + m_q - 1) / m_q;
    if (k < 1) k = 1;
    while (k % 4 != 0) k++;
    return m_s + k * m_q;
  endfunction
  // expected {busy,a,b,c,sync,pos,rev} sampled after posedge n
  function automatic logic [36:0] expect_at(input int n);
    int kp, k, q, j, p;
    logic run, a, b, c, sy;
    kp = steps_at(n - 1);
    k = steps_at(n);
    q = qv(kp);
    run = (n - 1 >= m_s) && (n - 1 < m_e);
    a = (q == 1) || (q == 2);
    b = (q == 2) || (q == 3);
    c = run && q == 0 && posv(kp / 4) == 0;
    sy = 1'b0;
    j = n - 1 - m_s;
    if (j > 0 && n - 1 <= m_e && j % m_q == 0 && (j / m_q) % 4 == 0) begin
      p = j / m_q / 4;
      sy = m_d != 0 && wraps(p) > wraps(p - 1) && wraps(p) % m_d == 0;
    end
    return {run, a, b, c, sy, 16'(posv(k / 4)), 16'(m_rev0 + wraps(k / 4))};
  endfunction
  function automatic logic [36:0] obs();
    return {busy, enc_a, enc_b, enc_c, enc_sync, pulse_pos, rev_cnt};
  endfunction

  task automatic check(input string tag, input logic [36:0] got, input logic [36:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got busy/a/b/c/sync=%b pos=%0d rev=%0d want %b pos=%0d rev=%0d",
               tag, cyc, got[36:32], got[31:16], got[15:0], want[36:32], want[31:16], want[15:0]);
    end
  endtask
  task automatic run_cycles(input int n, input string tag);
    repeat (n) begin
      exp_q.push_back(expect_at(cyc + 1));
      @(negedge clk);
      check(tag, obs(), exp_q.pop_front());
    end
  endtask
  task automatic load(input int q, input int ppr, input int d, input int dir);
    cfg_quarter = 24'(q);
    cfg_ppr = 16'(ppr);
    cfg_sync_div = 8'(d);
    cfg_dir = dir[0];
    cfg_load = 1'b1;
    sh_q = (q == 0) ? 1 : q;
    sh_ppr = ppr;
    sh_d = d;
    sh_dir = dir;
    run_cycles(1, "load");
    cfg_load = 1'b0;
  endtask
  task automatic start_gen();
    m_rev0 = cur_rev();
    m_s = cyc + 1;
    m_e = BIG;
    m_q = sh_q;
    m_ppr = sh_ppr;
    m_d = sh_d;
    m_dir = sh_dir;
    gen_en = 1'b1;
  endtask
  task automatic stop_gen(input string tag);
    gen_en = 1'b0;
    m_e = next_land(cyc + 1);
    run_cycles(m_e - cyc + 3, tag);
  endtask

  initial begin
    #1 mcu_n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", obs(), '0);
    mcu_n_rst = 1'b1;
    run_cycles(4, "idle");
    load(5, 4, 1, 0);
    start_gen();
    run_cycles(172, "fwd");
    check("at_q2", {35'b0, enc_a, enc_b}, 37'b11);
    stop_gen("stop_q2");
    start_gen();
    run_cycles(60, "restart");
    load(2, 4, 2, 0);
    run_cycles(40, "midload");
    stop_gen("stop_mid");
    start_gen();
    run_cycles(110, "quarter2");
    stop_gen("stop_q2run");
    load(5, 4, 1, 1);
    start_gen();
    run_cycles(120, "reverse");
    stop_gen("stop_rev");
    load(5, 4, 1, 0);
    start_gen();
    run_cycles(7, "pre_rst");
    #2 mcu_n_rst = 1'b0;
    gen_en = 1'b0;
    #1 check("async_rst", obs(), '0);
    m_s = BIG;
    m_e = BIG;
    m_rev0 = 0;
    @(negedge clk);
    check("rst_hold", obs(), '0);
    mcu_n_rst = 1'b1;
    run_cycles(4, "post_rst");
    load(0, 2, 1, 0);
    start_gen();
    run_cycles(30, "quarter0");
    stop_gen("stop_q0");
`ifdef ENC_BURST_EN
    cfg_burst = 32'd3;
    load(0, 2, 1, 0);
    start_gen();
    m_e = m_s + 12 * m_q;
    repeat (20) begin
      run_cycles(1, "burst");
      check("burst_done", {36'b0, burst_done}, {36'b0, cyc == m_e});
    end
    gen_en = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/encoder_gen.md
Name: encoder_gen

Overview:
- Encoder-signal emulator: the transmit end of the encoder measurement path.
- Generates a quadrature A/B pair, a once-per-revolution C index and a periodic sync strobe, with programmable speed, resolution and direction.
- Its outputs drive the ch_sgn_in / ch_c_in / ch_sync inputs of the measurement chain for bench self-test and field calibration.
- Configured by the MCU through a parallel load strobe; runs in the same clk domain as the sampler.

Parameters:
- CNT_W, 24, width of the quarter-period counter (clk cycles per quadrature state).
- PPR_W, 16, width of the pulses-per-revolution setting and position counter.
- SYNC_W, 8, width of the revolutions-per-sync divider.

Ports:
- clk  input  1  system clock.
- mcu_n_rst  input  1  asynchronous active-low reset.
- gen_en  input  1  level; rising edge while IDLE starts generation, low requests stop.
- cfg_load  input  1  one-clk strobe; latches the cfg_* inputs into shadow registers.
- cfg_quarter  input  CNT_W  clk cycles per quadrature state; 0 is treated as 1.
- cfg_ppr  input  PPR_W  pulses per revolution; 0 is treated as 2^PPR_W.
- cfg_sync_div  input  SYNC_W  revolutions per sync pulse; 0 disables sync.
- cfg_dir  input  1  0 = forward (A leads B), 1 = reverse.
- enc_a, enc_b  output  1  quadrature outputs, registered.
- enc_c  output  1  index output, registered.
- enc_sync  output  1  one-clk sync strobe.
- pulse_pos  output  PPR_W  position within the revolution.
- rev_cnt  output  16  revolutions completed, wraps.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset values:
  - All outputs 0; shadow cfg = {quarter 1, ppr 0, sync_div 0, dir 0}.
  - State IDLE; phase q = 0; qcnt = 0.
- Config handling:
  - cfg_load is accepted in any state into the shadow registers.
  - Working registers copy the shadow only on the IDLE->RUN transition, so a mid-run cfg_load has no effect until the next start.
- States:
  - IDLE: on gen_en rising edge (registered compare), go to RUN. qcnt, q, pulse_pos and sync divider clear; rev_cnt holds.
  - RUN: qcnt counts 0..quarter-1. At the terminal count, qcnt returns to 0 and q advances (+1 mod 4 forward, -1 mod 4 reverse). If gen_en is low, go to STOP.
  - STOP: keep stepping until the next step that lands on q = 0, then IDLE. If gen_en rises again before that, return to RUN without a restart.
- Phase encoding (registered, 1 clk after the q update):
  - q = 0 → A0 B0; q = 1 → A1 B0; q = 2 → A1 B1; q = 3 → A0 B1.
- Pulse position:
  - Each step onto q = 0 is a pulse.
  - Forward: pulse_pos increments, wrapping ppr-1 → 0.
  - Reverse: pulse_pos decrements, wrapping 0 → ppr-1.
  - Each wrap is one revolution: rev_cnt +1, sync divider +1.
- Index: enc_c = 1 while q = 0 and pulse_pos = 0, i.e. a single quarter-state wide pulse. It is 1 immediately after start.
- Sync:
  - When the divider reaches cfg_sync_div-1 on a revolution, enc_sync pulses for 1 clk, simultaneous with the enc_c rising edge, and the divider clears.
  - With cfg_sync_div = 1, sync occurs every revolution.
- Pulse rate: one full A period = 4·quarter clks.
- Edge cases:
  - quarter = 1 gives a step every clk.
  - A stop request on the same clk as a step that reaches q = 0 goes directly to IDLE.
- Reset mid-run: immediate asynchronous return to reset values; no partial pulse is completed.

Optional Feature:
- ENC_BURST_EN defined:
  - Adds ports cfg_burst (input, 32: pulse count, 0 = unlimited) and burst_done (output, 1-clk strobe).
  - RUN enters STOP automatically once cfg_burst pulses have been emitted. burst_done fires on the resulting IDLE entry.
- Undefined: those ports and logic are absent; only gen_en stops generation.

Decomposition:
- Package encoder_gen_pkg:
  - state encoding IDLE/RUN/STOP;
  - 2-bit phase constants Q0..Q3;
  - A/B lookup function;
  - default widths.
- Sub-module enc_quarter_timer: loadable down-counter emitting a one-clk step strobe every cfg_quarter clks, with zero-to-one substitution.

Test Plan:
- quarter = 5, ppr = 4, dir = 0, sync_div = 1, start → A period 20 clks, A leads B by 5 clks, enc_c high 5 clks every 80 clks, enc_sync coincident with the enc_c rise, rev_cnt +1 per 80 clks.
- Same config with dir = 1 → B leads A; pulse_pos sequence 0,3,2,1,0; enc_c still at pos 0.
- Drop gen_en mid-state (q = 2) → outputs continue until A = B = 0 at q = 0; busy falls the same clk; restart resumes with the latched config.
- cfg_load of quarter = 2 during RUN → period unchanged until stop/restart, then A period 8 clks.
- Assert mcu_n_rst at q = 1 → all outputs 0 asynchronously; after release, IDLE with busy = 0.
- ENC_BURST_EN, cfg_burst = 3, quarter = 1 → exactly 3 A pulses, burst_done 1 clk at IDLE entry; quarter = 0 behaves as 1.
